// File: rtl/epp_pkg.sv
// Shared types and helpers for the EPP host engine and its support blocks.
package epp_pkg;

  localparam int EPP_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RELEASE,
    ABORT
  } epp_state_t;

  // Cycle type packs {address, write} so one latched field carries both choices.
  typedef enum logic [1:0] {
    CYC_DATA_RD = 2'b00,
    CYC_DATA_WR = 2'b01,
    CYC_ADDR_RD = 2'b10,
    CYC_ADDR_WR = 2'b11
  } epp_cycle_t;

  function automatic epp_cycle_t make_cycle(input logic addr, input logic write);
    return epp_cycle_t'({addr, write});
  endfunction

  function automatic logic is_addr(input epp_cycle_t c);
    return (c == CYC_ADDR_RD) || (c == CYC_ADDR_WR);
  endfunction

  function automatic logic is_write(input epp_cycle_t c);
    return (c == CYC_DATA_WR) || (c == CYC_ADDR_WR);
  endfunction

endpackage

// File: rtl/epp_sync.sv
// Multi-flop bit synchroniser for bringing an asynchronous level into clk.
module epp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous input down the flop chain; only the last stage is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/epp_host.sv
// Host-side EPP engine: runs one interlocked address/data cycle per accepted command.
module epp_host
  import epp_pkg::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_addr,
  input  logic                  cmd_write,
  input  logic [EPP_DATA_W-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [EPP_DATA_W-1:0] rsp_data,
  output logic                  timeout,
  output logic                  EppAstb,
  output logic                  EppDstb,
  output logic                  EppWR,
  input  logic                  EppWait,
  inout  wire  [EPP_DATA_W-1:0] EppDB
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  epp_state_t            state, next_state;
  logic [CNT_W-1:0]      cnt, cnt_next, cnt_sat;
  epp_cycle_t            cyc, cyc_next;
  logic [EPP_DATA_W-1:0] wdata;
  logic                  wait_s;
  logic                  started;
  logic                  accept;
  logic                  rsp_pulse;
  logic                  drive;
  logic                  strobe_next;
  logic                  bus_next;

  epp_sync #(.STAGES(SYNC_STAGES)) u_wait_sync (
    .clk (clk),
    .rst (rst),
    .d   (EppWait),
    .q   (wait_s)
  );

  assign cmd_ready   = started && (state == IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign timeout     = (state == ABORT);
  assign cnt_sat     = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign cyc_next    = accept ? make_cycle(cmd_addr, cmd_write) : cyc;
  assign strobe_next = (next_state == STROBE) || (next_state == HOLD);
  assign bus_next    = strobe_next || (next_state == SETUP);
  assign EppDB       = drive ? wdata : 'z;

  // Next-state and counter decisions; every wait on the peripheral uses the synced wait_s.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    rsp_pulse  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = SETUP;
          cnt_next   = '0;
        end
      end
      SETUP: begin
        if (cnt < SETUP_LAST) begin
          cnt_next = cnt_sat;
        end else if (!wait_s) begin
          next_state = STROBE;
          cnt_next   = '0;
        end
      end
      STROBE: begin
        if (wait_s) begin
          next_state = HOLD;
        end else if (cnt >= TIMEOUT_LAST) begin
          next_state = ABORT;
        end else begin
          cnt_next = cnt_sat;
        end
      end
      HOLD: begin
        next_state = RELEASE;
        cnt_next   = '0;
      end
      RELEASE: begin
        if (!wait_s) begin
          next_state = IDLE;
          rsp_pulse  = 1'b1;
        end else if (cnt >= TIMEOUT_LAST) begin
          next_state = ABORT;
        end else begin
          cnt_next = cnt_sat;
        end
      end
      ABORT: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, counter and the one-shot "out of reset" flag that gates cmd_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      started <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= cnt_next;
      started <= 1'b1;
    end
  end

  // Command latch on accept, read capture in HOLD, and the completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc       <= CYC_DATA_RD;
      wdata     <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      cyc       <= cyc_next;
      rsp_valid <= rsp_pulse;
      if (accept) begin
        wdata <= cmd_data;
      end
      if ((state == HOLD) && !is_write(cyc)) begin
        rsp_data <= EppDB;
      end
    end
  end

  // Pin registers decoded from the next state so strobes and EppWR never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EppAstb <= 1'b1;
      EppDstb <= 1'b1;
      EppWR   <= 1'b1;
      drive   <= 1'b0;
    end else begin
      EppAstb <= !(strobe_next && is_addr(cyc_next));
      EppDstb <= !(strobe_next && !is_addr(cyc_next));
      EppWR   <= !(bus_next && is_write(cyc_next));
      drive   <= bus_next && is_write(cyc_next);
    end
  end

endmodule

// File: doc/epp_host.md
Name: epp_host

Overview:
- Host-side (initiator) EPP port engine.
- Turns single-byte commands (address write, data write, data read) into EPP strobe/wait handshakes on EppAstb/EppDstb/EppWR/EppDB.
- Drives the graphics register-file peripheral from on-chip logic: bring-up sequencers, self-test, loopback benches.
- Fully interlocked: every cycle waits on EppWait, with timeout protection.

Parameters:
- SETUP_CYCLES, 2, clocks EppDB/EppWR are held stable before the strobe falls (min 1).
- TIMEOUT_CYCLES, 1023, max clocks spent waiting for an EppWait edge before abort (10-bit counter).
- SYNC_STAGES, 2, flip-flop stages synchronising EppWait into clk.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
- cmd_addr  in  1  1 = address cycle (EppAstb), 0 = data cycle (EppDstb)
- cmd_write  in  1  1 = write, 0 = read (address reads legal)
- cmd_data  in  8  write byte
- rsp_valid  out  1  one-clock pulse: cycle completed normally
- rsp_data  out  8  byte sampled on reads; holds last value otherwise
- timeout  out  1  one-clock pulse: cycle aborted
- EppAstb  out  1  address strobe, active low
- EppDstb  out  1  data strobe, active low
- EppWR  out  1  0 = write, 1 = read
- EppWait  in  1  peripheral ready, active high, asynchronous to clk
- EppDB  inout  8  bidirectional data bus

Behaviour:
- Reset values: EppAstb=1, EppDstb=1, EppWR=1, EppDB=Z, cmd_ready=0 (1 from first clock after reset release), rsp_valid=0, timeout=0, rsp_data=0, FSM=IDLE.
- Synchroniser: EppWait passes through SYNC_STAGES flops; all FSM decisions use the synced value wait_s.
- Bus drive: EppDB is driven from the registered cmd_data only when the latched command is a write, in SETUP/STROBE/HOLD. Otherwise it is Z.
- On accept, latch cmd_addr, cmd_write, cmd_data. EppWR follows ~write from SETUP through HOLD; it is 1 otherwise.
- FSM:
  - IDLE: cmd_ready=1. On accept -> SETUP, counter=0.
    - If wait_s=1 in IDLE (peripheral still busy), accept is still permitted, but STROBE is not entered until wait_s=0.
  - SETUP: strobes high, bus/WR driven. After SETUP_CYCLES clocks and wait_s=0 -> STROBE, counter cleared.
  - STROBE: selected strobe low. wait_s=1 -> HOLD. Counter reaching TIMEOUT_CYCLES -> ABORT.
  - HOLD (1 clock): strobe still low. On reads, sample EppDB into rsp_data. Next clock strobe goes high -> RELEASE, counter cleared.
  - RELEASE: strobes high, bus Z, EppWR=1. wait_s=0 -> IDLE with rsp_valid pulse. Counter reaching TIMEOUT_CYCLES -> ABORT.
  - ABORT (1 clock): strobes high, bus Z, timeout pulse, rsp_data unchanged -> IDLE.
- Latency: zero-delay peripheral with SYNC_STAGES=2, SETUP_CYCLES=2 gives 2 (setup) + 3 (strobe to wait_s) + 1 (hold) + 3 (release) = 9 clocks from accept to rsp_valid.
- Only one strobe is ever low at a time. Both strobes are never low together, including across reset.
- Strobe outputs and EppWR are registered (glitch-free).
- Reset mid-cycle: strobes return high and the bus goes Z asynchronously. The aborted command is lost, with no rsp_valid and no timeout.
- Timeout counter saturates. It is 10 bits at the default; width is $clog2(TIMEOUT_CYCLES+1).
- Back-to-back: a new command may be accepted in the clock after rsp_valid (cmd_ready already high).

Decomposition:
- Shared package epp_pkg: state enum (IDLE, SETUP, STROBE, HOLD, RELEASE, ABORT); EPP_DATA_W=8; cycle-type encodings.
- Sub-module epp_sync: SYNC_STAGES-deep bit synchroniser, reusable by the peripheral side.
- Tristate buffer stays in the top.

Test Plan:
- Address write 0x0C, peripheral model with 2-clock Wait delay:
  - EppWR=0, EppDB=0x0C before EppAstb falls, EppDstb stays high.
  - One rsp_valid, no timeout.
- Data read, model drives 0x5A while EppDstb is low:
  - rsp_data=0x5A at rsp_valid.
  - EppDB is Z on the host side throughout; EppWR=1.
- Sequence addr 0x00, data 0x14, addr 0x02, data 0x28 back-to-back:
  - Model register file ends with regs[0]=0x14, regs[2]=0x28.
  - Exactly four rsp_valid pulses.
  - Strobes never overlap.
- Model never raises Wait, TIMEOUT_CYCLES=15: exactly 15 clocks of STROBE, then a timeout pulse, strobes high, cmd_ready high; rsp_data unchanged.
- Model holds Wait high for 40 clocks after strobe release:
  - Host stays in RELEASE.
  - rsp_valid only after wait_s falls.
  - The next queued command does not strobe until then.
- Assert rst while EppDstb is low:
  - EppDstb=1 and EppDB=Z in the same cycle (async).
  - No rsp_valid or timeout.
  - cmd_ready=1 one clock after rst releases.
